// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
//   Shares one single-port data memory (combinational read, posedge write)
//   between two requesters: port 0 (CPU load/store) and port 1 (DMA/debug
//   loader). Each port uses a req/ack handshake. Round-robin arbitration
//   decides ties, and each transaction takes three cycles:
//   IDLE (sample) -> ACCESS (memory cycle) -> RESP (ack pulse).
//   This block is the memory's only driver.
//
// Parameters
//   DATA_W   data width of the ports and the memory
//   ADDR_HI  top bit of the byte address; word addresses are [ADDR_HI:2]
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   mX_req               request, held high until mX_ack
//   mX_we                1 = write, 0 = read (stable while mX_req)
//   mX_addr              word address (stable while mX_req)
//   mX_wdata             write data (stable while mX_req)
//   mX_rdata             read data, valid with mX_ack and held afterwards
//   mX_ack               one-cycle completion pulse
//   busy                 high whenever the FSM is not in IDLE
//   dm_addr/dm_din       memory address / write data, from the latches
//   dm_we                memory write enable, only in ACCESS
//   dm_dout              memory combinational read data
// -----------------------------------------------------------------------------
module dm_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_HI = 11
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_HI-2:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_HI-2:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,

  output logic              busy,

  output logic [ADDR_HI-2:0] dm_addr,
  output logic [DATA_W-1:0] dm_din,
  output logic              dm_we,
  input  logic [DATA_W-1:0] dm_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Port that was granted most recently; reset to 1 so port 0 wins the
  // first tie.
  logic last;

  // Transaction latched at the IDLE sample edge.
  logic               win;
  logic               lat_we;
  logic [ADDR_HI-2:0] lat_addr;
  logic [DATA_W-1:0]  lat_wdata;

  // Arbitration result for the current IDLE cycle.
  logic               grant_valid;
  logic               grant_id;
  logic               sel_we;
  logic [ADDR_HI-2:0] sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  // Round-robin choice: a lone requester always wins, on a tie the port
  // that was not served last wins.
  always_comb begin
    grant_valid = m0_req | m1_req;
    grant_id    = 1'b0;
    if (m0_req && m1_req) begin
      grant_id = ~last;
    end else if (m1_req) begin
      grant_id = 1'b1;
    end
  end

  // Only the winner's request fields reach the latches.
  always_comb begin
    sel_we    = m0_we;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (grant_id) begin
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  // Next state and state-decoded outputs. dm_we and the acks are pure
  // functions of the state, so an asynchronous reset removes them at once
  // (no write is performed if reset lands in ACCESS, and an ack in RESP is
  // cut immediately).
  always_comb begin
    state_nxt = state;
    dm_we     = 1'b0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        busy      = 1'b1;
        dm_we     = lat_we;
        state_nxt = RESP;
      end
      RESP: begin
        busy      = 1'b1;
        m0_ack    = ~win;
        m1_ack    = win;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the winning request at the IDLE sample edge. The latches keep
  // their values afterwards so dm_addr/dm_din stay stable in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win       <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (state == IDLE && grant_valid) begin
      win       <= grant_id;
      lat_we    <= sel_we;
      lat_addr  <= sel_addr;
      lat_wdata <= sel_wdata;
    end
  end

  // The round-robin pointer advances when the access actually happens, so
  // a transaction aborted by reset does not count as served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (state == ACCESS) begin
      last <= win;
    end
  end

  // Read data is captured at the end of ACCESS into the winner's register
  // only; writes and the other port's transactions leave it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if (state == ACCESS && !lat_we) begin
      if (win) begin
        m1_rdata <= dm_dout;
      end else begin
        m0_rdata <= dm_dout;
      end
    end
  end

  assign dm_addr = lat_addr;
  assign dm_din  = lat_wdata;

endmodule
